// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decoded ID operands/control in, registered EX copies and
// hazard status out.
`timescale 1ns/1ps
interface id_ex_if #(
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ALU_W  = 3;

  logic              Flush;
  logic              Hold;
  logic [REG_W-1:0]  rs_2;
  logic [REG_W-1:0]  rt_2;
  logic [REG_W-1:0]  rd_2;
  logic              UsesRt_2;
  logic [DATA_W-1:0] busA_2;
  logic [DATA_W-1:0] busB_2;
  logic [DATA_W-1:0] imm_2;
  logic              RegWr_2;
  logic              ALUSrc_2;
  logic              MemRead_2;
  logic              MemWr_2;
  logic              MemtoReg_2;
  logic [ALU_W-1:0]  ALUctr_2;

  logic [REG_W-1:0]  rs_3;
  logic [REG_W-1:0]  rt_3;
  logic [REG_W-1:0]  rd_3;
  logic [DATA_W-1:0] busA_3;
  logic [DATA_W-1:0] busB_3;
  logic [DATA_W-1:0] imm_3;
  logic              RegWr_3;
  logic              ALUSrc_3;
  logic              MemRead_3;
  logic              MemWr_3;
  logic              MemtoReg_3;
  logic [ALU_W-1:0]  ALUctr_3;
  logic              Stall;
  logic [CNT_W-1:0]  BubbleCnt;

  modport master (
    output Flush, Hold, rs_2, rt_2, rd_2, UsesRt_2, busA_2, busB_2, imm_2,
           RegWr_2, ALUSrc_2, MemRead_2, MemWr_2, MemtoReg_2, ALUctr_2,
    input  rs_3, rt_3, rd_3, busA_3, busB_3, imm_3, RegWr_3, ALUSrc_3,
           MemRead_3, MemWr_3, MemtoReg_3, ALUctr_3, Stall, BubbleCnt
  );

  modport slave (
    input  Flush, Hold, rs_2, rt_2, rd_2, UsesRt_2, busA_2, busB_2, imm_2,
           RegWr_2, ALUSrc_2, MemRead_2, MemWr_2, MemtoReg_2, ALUctr_2,
    output rs_3, rt_3, rd_3, busA_3, busB_3, imm_3, RegWr_3, ALUSrc_3,
           MemRead_3, MemWr_3, MemtoReg_3, ALUctr_3, Stall, BubbleCnt
  );
endinterface

// File: rtl/id_ex_hazard.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash, hold
// freeze and a saturating count of load-use bubbles.
`timescale 1ns/1ps
module id_ex_hazard #(
  parameter int unsigned CNT_W = 16
) (
  input logic    clk,
  input logic    rst_n,
  id_ex_if.slave bus
);
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ALU_W  = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] busA;
    logic [DATA_W-1:0] busB;
    logic [DATA_W-1:0] imm;
    logic              RegWr;
    logic              ALUSrc;
    logic              MemRead;
    logic              MemWr;
    logic              MemtoReg;
    logic [ALU_W-1:0]  ALUctr;
  } ex_t;

  ex_t              id_pkt;
  ex_t              ex_q;
  ex_t              ex_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             lu;

  // Gather the ID-stage payload.
  always_comb begin
    id_pkt          = '0;
    id_pkt.rs       = bus.rs_2;
    id_pkt.rt       = bus.rt_2;
    id_pkt.rd       = bus.rd_2;
    id_pkt.busA     = bus.busA_2;
    id_pkt.busB     = bus.busB_2;
    id_pkt.imm      = bus.imm_2;
    id_pkt.RegWr    = bus.RegWr_2;
    id_pkt.ALUSrc   = bus.ALUSrc_2;
    id_pkt.MemRead  = bus.MemRead_2;
    id_pkt.MemWr    = bus.MemWr_2;
    id_pkt.MemtoReg = bus.MemtoReg_2;
    id_pkt.ALUctr   = bus.ALUctr_2;
  end

  // A load writing a nonzero register that the ID instruction reads.
  assign lu = ex_q.MemRead & ex_q.RegWr & (ex_q.rd != REG_W'(0)) &
              ((ex_q.rd == bus.rs_2) | (bus.UsesRt_2 & (ex_q.rd == bus.rt_2)));

  assign bus.Stall = lu & ~bus.Flush;

  // Priority: flush, hold, load-use bubble, normal capture.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (bus.Flush) begin
      ex_d = '0;
    end else if (!bus.Hold) begin
      if (lu) begin
        ex_d = '0;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        ex_d = id_pkt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.rs_3       = ex_q.rs;
  assign bus.rt_3       = ex_q.rt;
  assign bus.rd_3       = ex_q.rd;
  assign bus.busA_3     = ex_q.busA;
  assign bus.busB_3     = ex_q.busB;
  assign bus.imm_3      = ex_q.imm;
  assign bus.RegWr_3    = ex_q.RegWr;
  assign bus.ALUSrc_3   = ex_q.ALUSrc;
  assign bus.MemRead_3  = ex_q.MemRead;
  assign bus.MemWr_3    = ex_q.MemWr;
  assign bus.MemtoReg_3 = ex_q.MemtoReg;
  assign bus.ALUctr_3   = ex_q.ALUctr;
  assign bus.BubbleCnt  = cnt_q;
endmodule

// File: tb/tb_id_ex_hazard.sv
// Directed scoreboard bench for id_ex_hazard: a 16-bit-counter instance and a
// 2-bit-counter instance receive identical ID-stage stimulus.
`timescale 1ns/1ps
module tb_id_ex_hazard;
  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] imm;
    logic        RegWr;
    logic        ALUSrc;
    logic        MemRead;
    logic        MemWr;
    logic        MemtoReg;
    logic [2:0]  ALUctr;
  } ex_t;

  logic clk;
  logic rst_n;
  ex_t  id;
  logic uses_rt;
  logic flush;
  logic hold;
  ex_t  exq[$];
  ex_t  cur;
  int   exp_cnt;
  int   checks;
  int   failures;

  id_ex_if #(.CNT_W(16)) bus16 ();
  id_ex_if #(.CNT_W(2))  bus2 ();

  id_ex_hazard #(.CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus16));
  id_ex_hazard #(.CNT_W(2))  u_sat (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive();
    bus16.Flush = flush;        bus2.Flush = flush;
    bus16.Hold = hold;          bus2.Hold = hold;
    bus16.rs_2 = id.rs;         bus2.rs_2 = id.rs;
    bus16.rt_2 = id.rt;         bus2.rt_2 = id.rt;
    bus16.rd_2 = id.rd;         bus2.rd_2 = id.rd;
    bus16.UsesRt_2 = uses_rt;   bus2.UsesRt_2 = uses_rt;
    bus16.busA_2 = id.busA;     bus2.busA_2 = id.busA;
    bus16.busB_2 = id.busB;     bus2.busB_2 = id.busB;
    bus16.imm_2 = id.imm;       bus2.imm_2 = id.imm;
    bus16.RegWr_2 = id.RegWr;   bus2.RegWr_2 = id.RegWr;
    bus16.ALUSrc_2 = id.ALUSrc; bus2.ALUSrc_2 = id.ALUSrc;
    bus16.MemRead_2 = id.MemRead;   bus2.MemRead_2 = id.MemRead;
    bus16.MemWr_2 = id.MemWr;       bus2.MemWr_2 = id.MemWr;
    bus16.MemtoReg_2 = id.MemtoReg; bus2.MemtoReg_2 = id.MemtoReg;
    bus16.ALUctr_2 = id.ALUctr;     bus2.ALUctr_2 = id.ALUctr;
  endtask

  function automatic ex_t obs16();
    ex_t o;
    o.rs = bus16.rs_3;           o.rt = bus16.rt_3;         o.rd = bus16.rd_3;
    o.busA = bus16.busA_3;       o.busB = bus16.busB_3;     o.imm = bus16.imm_3;
    o.RegWr = bus16.RegWr_3;     o.ALUSrc = bus16.ALUSrc_3; o.MemRead = bus16.MemRead_3;
    o.MemWr = bus16.MemWr_3;     o.MemtoReg = bus16.MemtoReg_3;
    o.ALUctr = bus16.ALUctr_3;
    return o;
  endfunction

  function automatic int sat3(int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic push(input ex_t v);
    exq.push_back(v);
    cur = v;
  endtask

  // Called at a falling edge with id/flush/hold set; ends at the next falling edge.
  task automatic step(input string tag, input bit exp_stall, input bit counted);
    ex_t e;
    drive();
    #1;
    chk({tag, "_stall"}, {bus16.Stall, bus2.Stall}, {exp_stall, exp_stall});
    if (counted) exp_cnt++;
    @(posedge clk);
    #1;
    checks++;
    assert (exq.size() != 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (exq.size() != 0) begin
      e = exq.pop_front();
      chk({tag, "_ex"}, obs16(), e);
    end
    chk({tag, "_cnt16"}, bus16.BubbleCnt, exp_cnt);
    chk({tag, "_cnt2"}, bus2.BubbleCnt, sat3(exp_cnt));
    @(negedge clk);
  endtask

  function automatic ex_t lw(input logic [4:0] rd);
    ex_t v = '0;
    v.rs = 5'd1; v.rt = rd; v.rd = rd; v.busA = 32'h100; v.imm = 32'h4;
    v.RegWr = 1'b1; v.ALUSrc = 1'b1; v.MemRead = 1'b1; v.MemtoReg = 1'b1;
    return v;
  endfunction

  function automatic ex_t alu(input logic [4:0] rs, input logic [4:0] rt);
    ex_t v = '0;
    v.rs = rs; v.rt = rt; v.rd = 5'd10; v.busA = 32'hA5A5_0001;
    v.busB = 32'h0000_00FF; v.RegWr = 1'b1; v.ALUctr = 3'd1;
    return v;
  endfunction

  initial begin
    checks = 0; failures = 0; exp_cnt = 0;
    id = '0; uses_rt = 1'b0; flush = 1'b0; hold = 1'b0; cur = '0;
    rst_n = 1'b0;
    drive();
    #12;
    chk("reset_ex", obs16(), 128'h0);
    chk("reset_stall", {bus16.Stall, bus2.Stall}, 2'b00);
    chk("reset_cnt", {bus16.BubbleCnt, bus2.BubbleCnt}, 18'h0);
    @(negedge clk);
    rst_n = 1'b1;

    id = '0; id.rs = 5'd3; id.rt = 5'd4; id.rd = 5'd5; id.imm = 32'hFFFF_FFF0;
    id.ALUctr = 3'd2; id.RegWr = 1'b1; id.busA = 32'h11; id.busB = 32'h22;
    push(id); step("pass", 1'b0, 1'b0);

    // load-use on rs
    id = lw(5'd8); push(id); step("lw8", 1'b0, 1'b0);
    id = alu(5'd8, 5'd2); uses_rt = 1'b1;
    push('0); step("lu_rs_bubble", 1'b1, 1'b1);
    push(id); step("lu_rs_issue", 1'b0, 1'b0);

    // rt match gated by UsesRt_2
    id = lw(5'd9); push(id); step("lw9a", 1'b0, 1'b0);
    id = alu(5'd1, 5'd9); uses_rt = 1'b0;
    push(id); step("rt_unused", 1'b0, 1'b0);
    id = lw(5'd9); push(id); step("lw9b", 1'b0, 1'b0);
    id = alu(5'd1, 5'd9); uses_rt = 1'b1;
    push('0); step("lu_rt_bubble", 1'b1, 1'b1);
    push(id); step("lu_rt_issue", 1'b0, 1'b0);

    // flush beats load-use
    id = lw(5'd8); push(id); step("lw8f", 1'b0, 1'b0);
    id = alu(5'd8, 5'd3); flush = 1'b1;
    push('0); step("flush_lu", 1'b0, 1'b0);
    flush = 1'b0;

    // hold with load-use: frozen for 3 edges, single bubble afterwards
    id = lw(5'd8); push(id); step("lw8h", 1'b0, 1'b0);
    id = alu(5'd8, 5'd3); hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(cur); step("hold_lu", 1'b1, 1'b0);
    end
    hold = 1'b0;
    push('0); step("hold_release_bubble", 1'b1, 1'b1);
    push(id); step("hold_issue", 1'b0, 1'b0);

    // lw $0 never stalls
    id = lw(5'd0); push(id); step("lw0", 1'b0, 1'b0);
    id = alu(5'd0, 5'd0); uses_rt = 1'b1;
    push(id); step("lw0_dep", 1'b0, 1'b0);

    // asynchronous reset between edges
    id = '0; id.RegWr = 1'b1; id.busA = 32'h1234;
    push(id); step("pre_reset", 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ex", obs16(), 128'h0);
    chk("async_reset_cnt", {bus16.BubbleCnt, bus2.BubbleCnt}, 18'h0);
    chk("async_reset_stall", {bus16.Stall, bus2.Stall}, 2'b00);
    #1 rst_n = 1'b1;
    exq.delete(); exp_cnt = 0;
    id = '0; uses_rt = 1'b0; drive();
    @(negedge clk);

    // saturation of the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      id = lw(5'd8); uses_rt = 1'b0;
      push(id); step("sat_lw", 1'b0, 1'b0);
      id = alu(5'd8, 5'd4);
      push('0); step("sat_bubble", 1'b1, 1'b1);
      push(id); step("sat_issue", 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
